// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style character-LCD bus: instruction
// masks, DDRAM layout, address wrap points and small decode/step helpers.
package lcd_pkg;

  // Instruction masks, one per "highest set bit" class
  localparam logic [7:0] INS_SET_DDRAM = 8'h80;
  localparam logic [7:0] INS_SET_CGRAM = 8'h40;
  localparam logic [7:0] INS_FUNC_SET  = 8'h20;
  localparam logic [7:0] INS_SHIFT     = 8'h10;
  localparam logic [7:0] INS_DISP_CTRL = 8'h08;
  localparam logic [7:0] INS_ENTRY     = 8'h04;
  localparam logic [7:0] INS_HOME      = 8'h02;
  localparam logic [7:0] INS_CLEAR     = 8'h01;

  localparam logic [7:0] CHAR_SPACE = 8'h20;

  // DDRAM layout of the 2x16 display
  localparam logic [6:0] LINE1_BASE = 7'h00;
  localparam logic [6:0] LINE2_BASE = 7'h40;
  localparam int         LINE_LEN   = 16;

  // Address wrap points between the two DDRAM lines
  localparam logic [6:0] LINE1_WRAP = 7'h27;
  localparam logic [6:0] LINE2_WRAP = 7'h67;

  localparam int DEF_BUSY_CYCLES  = 37;
  localparam int DEF_CLEAR_CYCLES = 1520;

  typedef enum logic [3:0] {
    OP_NOP,
    OP_CLEAR,
    OP_HOME,
    OP_ENTRY,
    OP_DISPLAY,
    OP_SHIFT,
    OP_FUNC,
    OP_CGRAM,
    OP_DDRAM
  } lcd_op_e;

  // Instruction class is selected by the highest set bit of the byte
  function automatic lcd_op_e decode_op(input logic [7:0] d);
    lcd_op_e op;
    op = OP_NOP;
    if      (|(d & INS_SET_DDRAM)) op = OP_DDRAM;
    else if (|(d & INS_SET_CGRAM)) op = OP_CGRAM;
    else if (|(d & INS_FUNC_SET))  op = OP_FUNC;
    else if (|(d & INS_SHIFT))     op = OP_SHIFT;
    else if (|(d & INS_DISP_CTRL)) op = OP_DISPLAY;
    else if (|(d & INS_ENTRY))     op = OP_ENTRY;
    else if (|(d & INS_HOME))      op = OP_HOME;
    else if (|(d & INS_CLEAR))     op = OP_CLEAR;
    return op;
  endfunction

  // 7-bit address step with the line1/line2 wrap points
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] n;
    if (inc) begin
      if      (a == LINE1_WRAP) n = LINE2_BASE;
      else if (a == LINE2_WRAP) n = LINE1_BASE;
      else                      n = a + 7'd1;
    end else begin
      if      (a == LINE2_BASE) n = LINE1_WRAP;
      else if (a == LINE1_BASE) n = LINE2_WRAP;
      else                      n = a - 7'd1;
    end
    return n;
  endfunction

  // True when the address falls on one of the 32 visible characters
  function automatic logic is_mapped(input logic [6:0] a);
    logic [6:0] off1;
    logic [6:0] off2;
    off1 = a - LINE1_BASE;
    off2 = a - LINE2_BASE;
    return (off1 < 7'(LINE_LEN)) || (off2 < 7'(LINE_LEN));
  endfunction

endpackage

// File: rtl/lcd_strobe_sync.sv
// Brings the asynchronous lcd_e strobe into the clk domain and flags its
// rising and falling edges as single-cycle pulses.
module lcd_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_e,
  output logic o_e_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Two-flop synchroniser followed by one delayed copy for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_e;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_e_sync = r_sync;
  assign o_rise   = r_sync & ~r_prev;
  assign o_fall   = ~r_sync & r_prev;

endmodule

// File: rtl/lcd_bus_receiver.sv
// Device end of the 8-bit character-LCD bus. Decodes instruction and data
// writes into a 2x16 DDRAM image, keeps the address counter and busy flag,
// and answers status and data reads.
// Bus handshake: rs/rw/data are sampled alongside the synchronised E; a write
// commits one cycle after the synchronised falling edge, and is accepted only
// when busy is clear (or expiring that cycle); reads drive lcd_dout with
// lcd_doe high for as long as synchronised E stays high.
module lcd_bus_receiver
  import lcd_pkg::*;
#(
  parameter int BUSY_CYCLES  = DEF_BUSY_CYCLES,
  parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         lcd_e,
  input  logic         lcd_rs,
  input  logic         lcd_rw,
  input  logic [7:0]   lcd_data,
  output logic [7:0]   lcd_dout,
  output logic         lcd_doe,
  output logic [127:0] line1_data,
  output logic [127:0] line2_data,
  output logic         display_on,
  output logic         busy,
  output logic         char_wr,
  output logic         overrun_err
);

  localparam int CNT_MAX = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] L_BUSY  = CNT_W'(BUSY_CYCLES);
  localparam logic [CNT_W-1:0] L_CLEAR = CNT_W'(CLEAR_CYCLES);

  logic w_e_sync;
  logic w_e_rise;
  logic w_e_fall;

  logic       r_rs_s1, r_rw_s1, r_rs_s2, r_rw_s2;
  logic [7:0] r_data_s1, r_data_s2;
  logic       r_rs_h, r_rw_h;
  logic [7:0] r_data_h;
  logic       r_fall_q;

  logic [6:0]       r_addr;
  logic             r_inc;
  logic             r_cg_mode;
  logic             r_display_on;
  logic [CNT_W-1:0] r_busy_cnt;
  logic [127:0]     r_line1;
  logic [127:0]     r_line2;
  logic             r_char_wr;
  logic             r_overrun;

  logic             w_busy;
  logic             w_blocked;
  logic             w_wr;
  logic             w_drop;
  logic             w_rd_step;
  lcd_op_e          w_op;
  logic [6:0]       w_step_addr;
  logic             w_mapped;
  logic [7:0]       w_rd_char;

  logic [6:0]       w_nx_addr;
  logic             w_nx_inc;
  logic             w_nx_cg;
  logic             w_nx_disp;
  logic             w_load;
  logic [CNT_W-1:0] w_load_val;
  logic             w_store;
  logic             w_clear_all;

  lcd_strobe_sync u_sync (
    .clk      (clk),
    .rst      (rst),
    .i_e      (lcd_e),
    .o_e_sync (w_e_sync),
    .o_rise   (w_e_rise),
    .o_fall   (w_e_fall)
  );

  // Bus fields pipelined to line up with the synchronised E, then held for the commit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rs_s1   <= 1'b0;
      r_rw_s1   <= 1'b0;
      r_data_s1 <= 8'h00;
      r_rs_s2   <= 1'b0;
      r_rw_s2   <= 1'b0;
      r_data_s2 <= 8'h00;
      r_rs_h    <= 1'b0;
      r_rw_h    <= 1'b0;
      r_data_h  <= 8'h00;
      r_fall_q  <= 1'b0;
    end else begin
      r_rs_s1   <= lcd_rs;
      r_rw_s1   <= lcd_rw;
      r_data_s1 <= lcd_data;
      r_rs_s2   <= r_rs_s1;
      r_rw_s2   <= r_rw_s1;
      r_data_s2 <= r_data_s1;
      if (w_e_rise) begin
        r_rs_h <= r_rs_s2;
        r_rw_h <= r_rw_s2;
      end
      if (w_e_sync) r_data_h <= r_data_s2;
      r_fall_q <= w_e_fall;
    end
  end

  assign w_busy      = (r_busy_cnt != '0);
  // A counter on its final cycle counts as expired so a coincident write is taken
  assign w_blocked   = (r_busy_cnt > CNT_W'(1));
  assign w_wr        = r_fall_q && !r_rw_h && !w_blocked;
  assign w_drop      = r_fall_q && !r_rw_h && w_blocked;
  assign w_rd_step   = r_fall_q && r_rw_h && r_rs_h;
  assign w_op        = decode_op(r_data_h);
  assign w_step_addr = addr_step(r_addr, r_inc);
  assign w_mapped    = is_mapped(r_addr);

  // Decode the committed access into next-state values for the control registers
  always_comb begin
    w_nx_addr   = r_addr;
    w_nx_inc    = r_inc;
    w_nx_cg     = r_cg_mode;
    w_nx_disp   = r_display_on;
    w_load      = 1'b0;
    w_load_val  = '0;
    w_store     = 1'b0;
    w_clear_all = 1'b0;
    if (w_wr && r_rs_h) begin
      w_load     = 1'b1;
      w_load_val = L_BUSY;
      // Data aimed at CGRAM is swallowed without touching the DDRAM address
      if (!r_cg_mode) begin
        w_store   = w_mapped;
        w_nx_addr = w_step_addr;
      end
    end else if (w_wr) begin
      case (w_op)
        OP_DDRAM: begin
          w_nx_addr  = r_data_h[6:0];
          w_nx_cg    = 1'b0;
          w_load     = 1'b1;
          w_load_val = L_BUSY;
        end
        OP_CGRAM: begin
          w_nx_cg    = 1'b1;
          w_load     = 1'b1;
          w_load_val = L_BUSY;
        end
        OP_FUNC, OP_SHIFT: begin
          w_load     = 1'b1;
          w_load_val = L_BUSY;
        end
        OP_DISPLAY: begin
          w_nx_disp  = r_data_h[2];
          w_load     = 1'b1;
          w_load_val = L_BUSY;
        end
        OP_ENTRY: begin
          w_nx_inc   = r_data_h[1];
          w_load     = 1'b1;
          w_load_val = L_BUSY;
        end
        OP_HOME: begin
          w_nx_addr  = LINE1_BASE;
          w_nx_cg    = 1'b0;
          w_load     = 1'b1;
          w_load_val = L_CLEAR;
        end
        OP_CLEAR: begin
          w_clear_all = 1'b1;
          w_nx_addr   = LINE1_BASE;
          w_nx_inc    = 1'b1;
          w_nx_cg     = 1'b0;
          w_load      = 1'b1;
          w_load_val  = L_CLEAR;
        end
        default: ;
      endcase
    end else if (w_rd_step) begin
      w_nx_addr = w_step_addr;
    end
  end

  // Control registers, busy down-counter and single-cycle event pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr       <= LINE1_BASE;
      r_inc        <= 1'b1;
      r_cg_mode    <= 1'b0;
      r_display_on <= 1'b0;
      r_busy_cnt   <= '0;
      r_char_wr    <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_addr       <= w_nx_addr;
      r_inc        <= w_nx_inc;
      r_cg_mode    <= w_nx_cg;
      r_display_on <= w_nx_disp;
      if (w_load)      r_busy_cnt <= w_load_val;
      else if (w_busy) r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      r_char_wr    <= w_store;
      r_overrun    <= w_drop;
    end
  end

  // DDRAM image: full blanking on clear, otherwise one character per stored write
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line1 <= {LINE_LEN{CHAR_SPACE}};
      r_line2 <= {LINE_LEN{CHAR_SPACE}};
    end else if (w_clear_all) begin
      r_line1 <= {LINE_LEN{CHAR_SPACE}};
      r_line2 <= {LINE_LEN{CHAR_SPACE}};
    end else if (w_store) begin
      if (r_addr[6]) r_line2[{r_addr[3:0], 3'b000} +: 8] <= r_data_h;
      else           r_line1[{r_addr[3:0], 3'b000} +: 8] <= r_data_h;
    end
  end

  assign w_rd_char = !w_mapped ? CHAR_SPACE :
                     (r_addr[6] ? r_line2[{r_addr[3:0], 3'b000} +: 8]
                                : r_line1[{r_addr[3:0], 3'b000} +: 8]);

  assign lcd_doe     = w_e_sync && r_rw_s2;
  assign lcd_dout    = !lcd_doe ? 8'h00 : (r_rs_s2 ? w_rd_char : {w_busy, r_addr});
  assign line1_data  = r_line1;
  assign line2_data  = r_line2;
  assign display_on  = r_display_on;
  assign busy        = w_busy;
  assign char_wr     = r_char_wr;
  assign overrun_err = r_overrun;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver: drives the LCD bus like the watch's
// driver, checks the DDRAM image, busy length, pulses and read-back values.
module tb_lcd_bus_receiver;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         lcd_e = 1'b0;
  logic         lcd_rs = 1'b0;
  logic         lcd_rw = 1'b0;
  logic [7:0]   lcd_data = 8'h00;
  logic [7:0]   lcd_dout;
  logic         lcd_doe;
  logic [127:0] line1_data;
  logic [127:0] line2_data;
  logic         display_on;
  logic         busy;
  logic         char_wr;
  logic         overrun_err;

  localparam logic [127:0] BLANK = {16{8'h20}};

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  int busy_run = 0;
  int last_busy_len = 0;
  int char_wr_cnt = 0;
  int ovr_cnt = 0;

  lcd_bus_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .lcd_e       (lcd_e),
    .lcd_rs      (lcd_rs),
    .lcd_rw      (lcd_rw),
    .lcd_data    (lcd_data),
    .lcd_dout    (lcd_dout),
    .lcd_doe     (lcd_doe),
    .line1_data  (line1_data),
    .line2_data  (line2_data),
    .display_on  (display_on),
    .busy        (busy),
    .char_wr     (char_wr),
    .overrun_err (overrun_err)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, failures=%0d", failures);
    $fatal(1, "watchdog expired");
  end

  // Monitor: length of each busy run and counts of the output pulses
  always @(negedge clk) begin
    if (!rst) busy_run = 0;
    else if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_busy_len = busy_run;
      busy_run = 0;
    end
    if (char_wr) char_wr_cnt++;
    if (overrun_err) ovr_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d);
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b0;
    lcd_data = d;
    last_busy_len = 0;
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    repeat (4) @(negedge clk);
    lcd_e = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic bus_read(input logic rs, input logic [7:0] exp, input string tag);
    int n;
    logic [7:0] e;
    @(negedge clk);
    lcd_rs = rs;
    lcd_rw = 1'b1;
    exp_q.push_back(exp);
    repeat (2) @(negedge clk);
    lcd_e = 1'b1;
    n = 0;
    while (!lcd_doe && n < 8) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_doe"}, lcd_doe, 1'b1);
    e = exp_q.pop_front();
    if (lcd_doe) check(tag, lcd_dout, e);
    repeat (3) @(negedge clk);
    lcd_e = 1'b0;
    repeat (5) @(negedge clk);
    lcd_rw = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 4000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, (n < 4000), 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wr(input logic rs, input logic [7:0] d, input string tag);
    bus_write(rs, d);
    wait_idle(tag);
  endtask

  initial begin
    int c0;
    int o0;
    logic [127:0] exp_line;
    logic [127:0] snap;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_doe", lcd_doe, 1'b0);
    check("rst_dout", lcd_dout, 8'h00);
    check("rst_line1", line1_data, BLANK);
    check("rst_line2", line2_data, BLANK);
    check("rst_disp", display_on, 1'b0);
    check("rst_pulses", {char_wr, overrun_err}, 2'b00);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Clear, set address, first character
    wr(1'b0, 8'h01, "clr1");
    check("clr1_len", last_busy_len, 1520);
    wr(1'b0, 8'h80, "set0");
    check("set0_len", last_busy_len, 37);
    c0 = char_wr_cnt;
    wr(1'b1, 8'h41, "d41");
    check("d41_line1", line1_data[7:0], 8'h41);
    check("d41_charwr", char_wr_cnt - c0, 1);
    check("d41_len", last_busy_len, 37);
    bus_read(1'b0, 8'h01, "st_after_41");

    // Last char of line 2, then unmapped 0x67 wrapping to 0x00
    wr(1'b0, 8'hCF, "set4f");
    wr(1'b1, 8'h5A, "d5a");
    check("d5a_line2", line2_data[127:120], 8'h5A);
    bus_read(1'b0, 8'h50, "st_after_4f");
    wr(1'b0, 8'hE7, "set67");
    c0 = char_wr_cnt;
    wr(1'b1, 8'h7E, "d7e_unmapped");
    check("unmapped_nochar", char_wr_cnt - c0, 0);
    bus_read(1'b0, 8'h00, "st_wrap_67");
    wr(1'b1, 8'h42, "d42");
    check("d42_line1", line1_data[7:0], 8'h42);

    // Increment across 0x27 -> 0x40
    wr(1'b0, 8'hA7, "set27");
    wr(1'b1, 8'h11, "d11");
    wr(1'b1, 8'h12, "d12");
    check("wrap27_line2", line2_data[7:0], 8'h12);

    // Fill line 1, then clear while reading the busy flag
    wr(1'b0, 8'h80, "fill_set");
    c0 = char_wr_cnt;
    exp_line = '0;
    for (int i = 0; i < 16; i++) begin
      wr(1'b1, 8'h30 + 8'(i), "fill");
      exp_line[8*i +: 8] = 8'h30 + 8'(i);
    end
    check("fill_line1", line1_data, exp_line);
    check("fill_charwr", char_wr_cnt - c0, 16);
    bus_write(1'b0, 8'h01);
    bus_read(1'b0, 8'h80, "st_busy_clear");
    wait_idle("clr2");
    check("clr2_len", last_busy_len, 1520);
    check("clr2_line1", line1_data, BLANK);
    check("clr2_line2", line2_data, BLANK);

    // Overrun: second data write lands while busy
    wr(1'b0, 8'h80, "ovr_set");
    o0 = ovr_cnt;
    c0 = char_wr_cnt;
    bus_write(1'b1, 8'h55);
    bus_write(1'b1, 8'h66);
    wait_idle("ovr");
    check("ovr_pulse", ovr_cnt - o0, 1);
    check("ovr_charwr", char_wr_cnt - c0, 1);
    check("ovr_line1", line1_data[15:0], 16'h2055);
    check("ovr_len", last_busy_len, 37);
    bus_read(1'b0, 8'h01, "st_after_ovr");

    // Decrement mode and the reverse wraps
    wr(1'b0, 8'h04, "dec");
    wr(1'b0, 8'h80, "dec_set0");
    wr(1'b1, 8'h31, "d31");
    check("d31_line1", line1_data[7:0], 8'h31);
    bus_read(1'b0, 8'h67, "st_dec_wrap");
    bus_read(1'b1, 8'h20, "rd_unmapped");
    bus_read(1'b0, 8'h66, "st_after_rd");
    wr(1'b0, 8'hC0, "dec_set40");
    wr(1'b1, 8'h77, "d77");
    check("d77_line2", line2_data[7:0], 8'h77);
    bus_read(1'b0, 8'h27, "st_dec_40");
    wr(1'b0, 8'h06, "inc");
    wr(1'b0, 8'h80, "inc_set0");
    bus_read(1'b1, 8'h31, "rd_data");
    bus_read(1'b0, 8'h01, "st_rd_step");

    // Display control
    wr(1'b0, 8'h0C, "disp_on");
    check("disp_on", display_on, 1'b1);
    wr(1'b0, 8'h08, "disp_off");
    check("disp_off", display_on, 1'b0);

    // CGRAM data is discarded until a DDRAM address is set
    snap = line1_data;
    c0 = char_wr_cnt;
    wr(1'b0, 8'h40, "cg");
    wr(1'b1, 8'h99, "cg_data");
    check("cg_line1", line1_data, snap);
    check("cg_charwr", char_wr_cnt - c0, 0);
    wr(1'b0, 8'h81, "cg_exit");
    wr(1'b1, 8'h44, "d44");
    check("d44_line1", line1_data[15:8], 8'h44);

    // No-op does not start busy
    bus_write(1'b0, 8'h00);
    check("nop_busy", busy, 1'b0);

    // Reset asserted while return-home is busy
    wr(1'b0, 8'h0C, "disp_on2");
    wr(1'b0, 8'hC5, "set45");
    wr(1'b1, 8'h4D, "d4d");
    bus_write(1'b0, 8'h02);
    repeat (50) @(negedge clk);
    check("home_busy", busy, 1'b1);
    rst = 1'b0;
    #1;
    check("rst2_busy", busy, 1'b0);
    check("rst2_line1", line1_data, BLANK);
    check("rst2_line2", line2_data, BLANK);
    check("rst2_disp", display_on, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    bus_read(1'b0, 8'h00, "st_after_rst");
    wr(1'b0, 8'h80, "post_set");
    wr(1'b1, 8'h48, "post_d48");
    check("post_line1", line1_data[7:0], 8'h48);
    check("post_len", last_busy_len, 37);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
